// File: rtl/pipe_controller_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, funct codes,
// control-word fields, forwarding selects and debug FSM states.
package pipe_controller_pkg;

    localparam int PC_SRC_W   = 3;
    localparam int EXE_A_W    = 2;
    localparam int EXE_B_W    = 2;
    localparam int EXE_ALU_W  = 4;
    localparam int WB_ADDR_W  = 2;
    localparam int FWD_W      = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [PC_SRC_W-1:0] PC_NEXT = 3'd0;
    localparam logic [PC_SRC_W-1:0] PC_JUMP = 3'd1;
    localparam logic [PC_SRC_W-1:0] PC_JR   = 3'd2;
    localparam logic [PC_SRC_W-1:0] PC_BEQ  = 3'd3;
    localparam logic [PC_SRC_W-1:0] PC_BNE  = 3'd4;

    localparam logic [EXE_A_W-1:0] EXE_A_RS   = 2'd0;
    localparam logic [EXE_A_W-1:0] EXE_A_LINK = 2'd1;
    localparam logic [EXE_A_W-1:0] EXE_A_SA   = 2'd2;

    localparam logic [EXE_B_W-1:0] EXE_B_RT   = 2'd0;
    localparam logic [EXE_B_W-1:0] EXE_B_IMM  = 2'd1;
    localparam logic [EXE_B_W-1:0] EXE_B_FOUR = 2'd2;

    localparam logic [EXE_ALU_W-1:0] EXE_ALU_ADD = 4'd0;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_SUB = 4'd1;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_AND = 4'd2;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_OR  = 4'd3;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_XOR = 4'd4;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_NOR = 4'd5;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_SLT = 4'd6;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_LUI = 4'd7;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_SLL = 4'd8;
    localparam logic [EXE_ALU_W-1:0] EXE_ALU_SRL = 4'd9;

    localparam logic [WB_ADDR_W-1:0] WB_ADDR_RD   = 2'd0;
    localparam logic [WB_ADDR_W-1:0] WB_ADDR_RT   = 2'd1;
    localparam logic [WB_ADDR_W-1:0] WB_ADDR_LINK = 2'd2;

    localparam logic WB_DATA_ALU = 1'b0;
    localparam logic WB_DATA_MEM = 1'b1;

    localparam logic [FWD_W-1:0] FWD_REG = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EXE = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;

    typedef enum logic [1:0] {
        DBG_RUN  = 2'd0,
        DBG_HALT = 2'd1,
        DBG_STEP = 2'd2
    } dbg_state_t;

    function automatic logic [EXE_ALU_W-1:0] rtype_alu_op(input logic [5:0] funct);
        case (funct)
            FN_SLL:          return EXE_ALU_SLL;
            FN_SRL:          return EXE_ALU_SRL;
            FN_SUB, FN_SUBU: return EXE_ALU_SUB;
            FN_AND:          return EXE_ALU_AND;
            FN_OR:           return EXE_ALU_OR;
            FN_XOR:          return EXE_ALU_XOR;
            FN_NOR:          return EXE_ALU_NOR;
            FN_SLT:          return EXE_ALU_SLT;
            default:         return EXE_ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight destination tracking for the EXE and MEM stages; produces the
// load-use stall and per-operand forwarding selects.
module pipe_scoreboard
    import pipe_controller_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic              exe_redirect,
    input  logic              id_wen,
    input  logic              id_mem_ren,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              uses_rs,
    input  logic              uses_rt,
    output logic              stall,
    output logic [FWD_W-1:0]  fwd_a_sel,
    output logic [FWD_W-1:0]  fwd_b_sel
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic              exe_wen_r;
    logic              exe_mem_ren_r;
    logic [REG_AW-1:0] exe_dest_r;
    logic              mem_wen_r;
    logic [REG_AW-1:0] mem_dest_r;
    logic              load_hit_s;

    // A load result is not available in EXE, so a load there only forwards from MEM.
    function automatic logic [FWD_W-1:0] fwd_select(
        input logic [REG_AW-1:0] src,
        input logic              e_wen,
        input logic              e_ren,
        input logic [REG_AW-1:0] e_dest,
        input logic              m_wen,
        input logic [REG_AW-1:0] m_dest
    );
        if (e_wen && !e_ren && (e_dest != REG_ZERO) && (e_dest == src)) begin
            return FWD_EXE;
        end else if (m_wen && (m_dest != REG_ZERO) && (m_dest == src)) begin
            return FWD_MEM;
        end else begin
            return FWD_REG;
        end
    endfunction

    // Hazard compare: load-use stall and forwarding selects, quiet during reset.
    always_comb begin
        load_hit_s = exe_mem_ren_r && exe_wen_r && (exe_dest_r != REG_ZERO) &&
                     ((uses_rs && (exe_dest_r == id_rs)) || (uses_rt && (exe_dest_r == id_rt)));
        if (rst) begin
            stall     = 1'b0;
            fwd_a_sel = FWD_REG;
            fwd_b_sel = FWD_REG;
        end else begin
            stall     = load_hit_s && !exe_redirect;
            fwd_a_sel = fwd_select(id_rs, exe_wen_r, exe_mem_ren_r, exe_dest_r, mem_wen_r, mem_dest_r);
            fwd_b_sel = fwd_select(id_rt, exe_wen_r, exe_mem_ren_r, exe_dest_r, mem_wen_r, mem_dest_r);
        end
    end

    // Entry pipeline: shifts only when the datapath is enabled; stall or flush inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_wen_r     <= 1'b0;
            exe_mem_ren_r <= 1'b0;
            exe_dest_r    <= REG_ZERO;
            mem_wen_r     <= 1'b0;
            mem_dest_r    <= REG_ZERO;
        end else if (cpu_en) begin
            mem_wen_r  <= exe_wen_r;
            mem_dest_r <= exe_dest_r;
            if (load_hit_s || exe_redirect) begin
                exe_wen_r     <= 1'b0;
                exe_mem_ren_r <= 1'b0;
                exe_dest_r    <= REG_ZERO;
            end else begin
                exe_wen_r     <= id_wen;
                exe_mem_ren_r <= id_mem_ren;
                exe_dest_r    <= id_dest;
            end
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Control unit for the 5-stage MIPS pipeline: decode, hazard control and an
// optional debug FSM (run/halt/step, PC breakpoint) enabled by CTRL_DEBUG_EN.
module pipe_controller
    import pipe_controller_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int PC_W   = 32,
    parameter int STEP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           inst,
    input  logic [PC_W-1:0]       id_pc,
    input  logic                  exe_redirect,
`ifdef CTRL_DEBUG_EN
    input  logic                  debug_en,
    input  logic                  debug_step,
    input  logic [STEP_W-1:0]     debug_step_cnt,
    input  logic                  bp_valid,
    input  logic [PC_W-1:0]       bp_pc,
    output logic                  dbg_halted,
`endif
    output logic [PC_SRC_W-1:0]   pc_src,
    output logic                  imm_ext,
    output logic [EXE_A_W-1:0]    exe_a_src,
    output logic [EXE_B_W-1:0]    exe_b_src,
    output logic [EXE_ALU_W-1:0]  exe_alu_oper,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [WB_ADDR_W-1:0]  wb_addr_src,
    output logic                  wb_data_src,
    output logic                  wb_wen,
    output logic                  unrecognized,
    output logic [FWD_W-1:0]      fwd_a_sel,
    output logic [FWD_W-1:0]      fwd_b_sel,
    output logic                  stall,
    output logic                  id_flush,
    output logic                  cpu_rst,
    output logic                  cpu_en
);

    localparam logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}};

    logic [5:0]        op_s;
    logic [5:0]        funct_s;
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;
    logic [REG_AW-1:0] rd_s;
    logic [REG_AW-1:0] id_dest_s;
    logic              uses_rs_s;
    logic              uses_rt_s;
    logic              unused_ok_s;

    assign op_s    = inst[31:26];
    assign funct_s = inst[5:0];
    assign rs_s    = inst[21 +: REG_AW];
    assign rt_s    = inst[16 +: REG_AW];
    assign rd_s    = inst[11 +: REG_AW];

    assign cpu_rst  = rst;
    assign id_flush = exe_redirect && !rst;

    // Instruction decode into the control word and register-use flags.
    always_comb begin
        pc_src       = PC_NEXT;
        imm_ext      = 1'b0;
        exe_a_src    = EXE_A_RS;
        exe_b_src    = EXE_B_RT;
        exe_alu_oper = EXE_ALU_ADD;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        wb_addr_src  = WB_ADDR_RD;
        wb_data_src  = WB_DATA_ALU;
        wb_wen       = 1'b0;
        unrecognized = 1'b0;
        uses_rs_s    = 1'b0;
        uses_rt_s    = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_SLL, FN_SRL: begin
                        exe_a_src    = EXE_A_SA;
                        exe_alu_oper = rtype_alu_op(funct_s);
                        wb_wen       = 1'b1;
                        uses_rs_s    = 1'b1;
                        uses_rt_s    = 1'b1;
                    end
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT: begin
                        exe_alu_oper = rtype_alu_op(funct_s);
                        wb_wen       = 1'b1;
                        uses_rs_s    = 1'b1;
                        uses_rt_s    = 1'b1;
                    end
                    FN_JR: begin
                        pc_src    = PC_JR;
                        uses_rs_s = 1'b1;
                    end
                    default: unrecognized = 1'b1;
                endcase
            end
            OP_J: pc_src = PC_JUMP;
            OP_JAL: begin
                pc_src      = PC_JUMP;
                exe_a_src   = EXE_A_LINK;
                exe_b_src   = EXE_B_FOUR;
                wb_addr_src = WB_ADDR_LINK;
                wb_wen      = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                pc_src       = (op_s == OP_BEQ) ? PC_BEQ : PC_BNE;
                imm_ext      = 1'b1;
                exe_alu_oper = EXE_ALU_SUB;
                uses_rs_s    = 1'b1;
                uses_rt_s    = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                imm_ext     = (op_s == OP_ADDI) || (op_s == OP_ADDIU) || (op_s == OP_SLTI);
                exe_b_src   = EXE_B_IMM;
                wb_addr_src = WB_ADDR_RT;
                wb_wen      = 1'b1;
                uses_rs_s   = 1'b1;
                case (op_s)
                    OP_SLTI: exe_alu_oper = EXE_ALU_SLT;
                    OP_ANDI: exe_alu_oper = EXE_ALU_AND;
                    OP_ORI:  exe_alu_oper = EXE_ALU_OR;
                    OP_XORI: exe_alu_oper = EXE_ALU_XOR;
                    default: exe_alu_oper = EXE_ALU_ADD;
                endcase
            end
            OP_LUI: begin
                exe_b_src    = EXE_B_IMM;
                exe_alu_oper = EXE_ALU_LUI;
                wb_addr_src  = WB_ADDR_RT;
                wb_wen       = 1'b1;
            end
            OP_LW: begin
                imm_ext     = 1'b1;
                exe_b_src   = EXE_B_IMM;
                mem_ren     = 1'b1;
                wb_addr_src = WB_ADDR_RT;
                wb_data_src = WB_DATA_MEM;
                wb_wen      = 1'b1;
                uses_rs_s   = 1'b1;
            end
            OP_SW: begin
                imm_ext   = 1'b1;
                exe_b_src = EXE_B_IMM;
                mem_wen   = 1'b1;
                uses_rs_s = 1'b1;
                uses_rt_s = 1'b1;
            end
            default: unrecognized = 1'b1;
        endcase
    end

    // Destination register of the ID-stage instruction as it will enter EXE.
    always_comb begin
        case (wb_addr_src)
            WB_ADDR_RT:   id_dest_s = rt_s;
            WB_ADDR_LINK: id_dest_s = LINK_REG;
            default:      id_dest_s = rd_s;
        endcase
    end

    pipe_scoreboard #(
        .REG_AW(REG_AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .exe_redirect (exe_redirect),
        .id_wen       (wb_wen),
        .id_mem_ren   (mem_ren),
        .id_dest      (id_dest_s),
        .id_rs        (rs_s),
        .id_rt        (rt_s),
        .uses_rs      (uses_rs_s),
        .uses_rt      (uses_rt_s),
        .stall        (stall),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
    );

`ifdef CTRL_DEBUG_EN
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

    dbg_state_t        state_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic              step_q_r;
    logic              bp_hit_s;
    logic              step_rise_s;

    assign bp_hit_s    = bp_valid && (id_pc == bp_pc);
    assign step_rise_s = debug_step && !step_q_r;
    assign dbg_halted  = (state_r == DBG_HALT) && !rst;
    assign unused_ok_s = ^inst[10:6];

    // Datapath enable: a breakpoint hit in RUN freezes the pipe in the same cycle.
    always_comb begin
        if (rst) begin
            cpu_en = 1'b1;
        end else begin
            case (state_r)
                DBG_RUN:  cpu_en = !bp_hit_s;
                DBG_STEP: cpu_en = 1'b1;
                default:  cpu_en = 1'b0;
            endcase
        end
    end

    // Debug FSM; stalled step cycles do not retire an instruction and are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DBG_RUN;
            step_cnt_r <= STEP_ZERO;
            step_q_r   <= 1'b0;
        end else begin
            step_q_r <= debug_step;
            case (state_r)
                DBG_RUN: begin
                    if (debug_en || bp_hit_s) begin
                        state_r <= DBG_HALT;
                    end
                end
                DBG_HALT: begin
                    if (step_rise_s) begin
                        step_cnt_r <= (debug_step_cnt == STEP_ZERO) ? STEP_ONE : debug_step_cnt;
                        state_r    <= DBG_STEP;
                    end else if (!debug_en && !bp_hit_s) begin
                        state_r <= DBG_RUN;
                    end
                end
                DBG_STEP: begin
                    if (!stall) begin
                        step_cnt_r <= step_cnt_r - STEP_ONE;
                        if (step_cnt_r <= STEP_ONE) begin
                            state_r <= DBG_HALT;
                        end
                    end
                end
                default: state_r <= DBG_RUN;
            endcase
        end
    end
`else
    assign cpu_en      = 1'b1;
    assign unused_ok_s = ^{inst[10:6], id_pc, (STEP_W > 0)};
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: decode, load-use stall, forwarding,
// redirect flush and (with CTRL_DEBUG_EN) the debug FSM.
module tb_pipe_controller;
    import pipe_controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] inst;
    logic [31:0] id_pc;
    logic        exe_redirect;
`ifdef CTRL_DEBUG_EN
    logic        debug_en;
    logic        debug_step;
    logic [7:0]  debug_step_cnt;
    logic        bp_valid;
    logic [31:0] bp_pc;
    logic        dbg_halted;
`endif
    logic [2:0]  pc_src;
    logic        imm_ext;
    logic [1:0]  exe_a_src;
    logic [1:0]  exe_b_src;
    logic [3:0]  exe_alu_oper;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  wb_addr_src;
    logic        wb_data_src;
    logic        wb_wen;
    logic        unrecognized;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic        id_flush;
    logic        cpu_rst;
    logic        cpu_en;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_controller dut (
        .clk(clk), .rst(rst), .inst(inst), .id_pc(id_pc), .exe_redirect(exe_redirect),
`ifdef CTRL_DEBUG_EN
        .debug_en(debug_en), .debug_step(debug_step), .debug_step_cnt(debug_step_cnt),
        .bp_valid(bp_valid), .bp_pc(bp_pc), .dbg_halted(dbg_halted),
`endif
        .pc_src(pc_src), .imm_ext(imm_ext), .exe_a_src(exe_a_src), .exe_b_src(exe_b_src),
        .exe_alu_oper(exe_alu_oper), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .wb_addr_src(wb_addr_src), .wb_data_src(wb_data_src), .wb_wen(wb_wen),
        .unrecognized(unrecognized), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .id_flush(id_flush), .cpu_rst(cpu_rst), .cpu_en(cpu_en)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] i);
        inst = i;
        #1;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0000;

`ifdef CTRL_DEBUG_EN
    task automatic count_step(input string tag, input int exp);
        int n;
        n = 0;
        for (int i = 0; i < 20 && dbg_halted !== 1'b1; i++) begin
            if (cpu_en === 1'b1) n++;
            tick;
        end
        check_eq(tag, n, exp);
        check_eq({tag, "_halted"}, dbg_halted, 1);
    endtask
`endif

    initial begin
        rst = 1'b1; exe_redirect = 1'b1; id_pc = 32'h0;
        inst = itype(OP_LW, 1, 2, 16'h0);
`ifdef CTRL_DEBUG_EN
        debug_en = 1'b1; debug_step = 1'b0; debug_step_cnt = 8'd0; bp_valid = 1'b0; bp_pc = 32'h0;
`endif
        tick; tick;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_flush", id_flush, 0);
        check_eq("rst_fwd_a", fwd_a_sel, 0);
        check_eq("rst_cpu_rst", cpu_rst, 1);
        check_eq("rst_cpu_en", cpu_en, 1);
`ifdef CTRL_DEBUG_EN
        check_eq("rst_halted", dbg_halted, 0);
        debug_en = 1'b0;
`endif
        inst = NOP; exe_redirect = 1'b0; rst = 1'b0;
        tick;
        check_eq("run_cpu_rst", cpu_rst, 0);

        // load-use then MEM forwarding
        drive(itype(OP_LW, 1, 2, 16'h0));
        check_eq("lw_mem_ren", mem_ren, 1);
        check_eq("lw_wb_data", wb_data_src, WB_DATA_MEM);
        check_eq("lw_wb_addr", wb_addr_src, WB_ADDR_RT);
        check_eq("lw_alu", exe_alu_oper, EXE_ALU_ADD);
        check_eq("lw_nostall", stall, 0);
        tick;
        drive(rtype(2, 4, 3, FN_ADD));
        check_eq("lu_stall", stall, 1);
        check_eq("lu_fwd_a", fwd_a_sel, FWD_REG);
        tick;
        check_eq("lu_stall_once", stall, 0);
        check_eq("lu_fwd_a_mem", fwd_a_sel, FWD_MEM);
        check_eq("lu_fwd_b", fwd_b_sel, FWD_REG);
        tick;

        // ALU-to-ALU forwarding
        drive(rtype(1, 1, 5, FN_ADD));
        check_eq("add5_fwd_a", fwd_a_sel, FWD_REG);
        tick;
        drive(rtype(5, 3, 6, FN_SUB));
        check_eq("sub_alu", exe_alu_oper, EXE_ALU_SUB);
        check_eq("mix_fwd_a", fwd_a_sel, FWD_EXE);
        check_eq("mix_fwd_b", fwd_b_sel, FWD_MEM);
        drive(rtype(5, 5, 6, FN_SUB));
        check_eq("exe_fwd_a", fwd_a_sel, FWD_EXE);
        check_eq("exe_fwd_b", fwd_b_sel, FWD_EXE);
        check_eq("exe_nostall", stall, 0);
        tick;

        // register 0 never forwarded, never stalls
        drive(rtype(6, 6, 0, FN_ADD));
        tick;
        drive(rtype(0, 0, 7, FN_SUB));
        check_eq("r0_fwd_a", fwd_a_sel, FWD_REG);
        check_eq("r0_fwd_b", fwd_b_sel, FWD_REG);
        tick;
        drive(itype(OP_LW, 1, 0, 16'h0));
        tick;
        drive(rtype(0, 7, 8, FN_ADD));
        check_eq("r0_load_nostall", stall, 0);
        check_eq("r0_load_fwd_a", fwd_a_sel, FWD_REG);
        check_eq("r0_mem_fwd_b", fwd_b_sel, FWD_MEM);
        tick;

        // EXE takes priority over MEM
        drive(itype(OP_ADDI, 8, 8, 16'h0005));
        check_eq("addi_b_src", exe_b_src, EXE_B_IMM);
        check_eq("addi_imm_ext", imm_ext, 1);
        check_eq("addi_fwd_a", fwd_a_sel, FWD_EXE);
        tick;
        drive(itype(OP_SW, 8, 8, 16'h0));
        check_eq("sw_mem_wen", mem_wen, 1);
        check_eq("sw_wb_wen", wb_wen, 0);
        check_eq("prio_fwd_a", fwd_a_sel, FWD_EXE);
        check_eq("prio_fwd_b", fwd_b_sel, FWD_EXE);
        tick;
        drive(rtype(8, 0, 9, FN_OR));
        check_eq("or_alu", exe_alu_oper, EXE_ALU_OR);
        check_eq("past_sw_fwd_a", fwd_a_sel, FWD_MEM);
        tick;

        // redirect beats load-use stall and bubbles EXE
        drive(itype(OP_LW, 1, 2, 16'h0));
        tick;
        drive(itype(OP_BEQ, 2, 3, 16'h0004));
        check_eq("beq_pc_src", pc_src, PC_BEQ);
        check_eq("beq_stall", stall, 1);
        exe_redirect = 1'b1;
        #1;
        check_eq("redir_flush", id_flush, 1);
        check_eq("redir_stall", stall, 0);
        tick;
        exe_redirect = 1'b0;
        #1;
        check_eq("post_flush_stall", stall, 0);
        check_eq("post_flush_fwd_a", fwd_a_sel, FWD_MEM);
        check_eq("post_flush_flush", id_flush, 0);

        drive(itype(OP_BNE, 1, 1, 16'hFFFC));
        check_eq("bne_pc_src", pc_src, PC_BNE);
        drive(itype(OP_LUI, 0, 4, 16'h1234));
        check_eq("lui_alu", exe_alu_oper, EXE_ALU_LUI);
        check_eq("lui_b_src", exe_b_src, EXE_B_IMM);
        check_eq("lui_wb_addr", wb_addr_src, WB_ADDR_RT);
        drive({OP_JAL, 26'h0000010});
        check_eq("jal_pc_src", pc_src, PC_JUMP);
        check_eq("jal_wb_addr", wb_addr_src, WB_ADDR_LINK);
        tick;
        drive(rtype(31, 0, 10, FN_ADD));
        check_eq("jal_link_fwd_a", fwd_a_sel, FWD_EXE);
        drive(32'hFC00_0000);
        check_eq("bad_op_unrec", unrecognized, 1);
        check_eq("bad_op_wb_wen", wb_wen, 0);
        drive(rtype(1, 2, 3, 6'h3F));
        check_eq("bad_fn_unrec", unrecognized, 1);
        drive(NOP);
        check_eq("nop_recognized", unrecognized, 0);
        tick; tick;

`ifdef CTRL_DEBUG_EN
        debug_en = 1'b1;
        #1;
        check_eq("dbg_req_cpu_en", cpu_en, 1);
        tick;
        check_eq("halt_halted", dbg_halted, 1);
        check_eq("halt_cpu_en", cpu_en, 0);
        drive(itype(OP_LW, 1, 12, 16'h0));
        tick; tick;
        drive(rtype(12, 0, 13, FN_ADD));
        check_eq("halt_frozen", stall, 0);
        drive(NOP);

        debug_step_cnt = 8'd3; debug_step = 1'b1;
        tick;
        count_step("step3", 3);
        tick; tick;
        check_eq("step_held_halted", dbg_halted, 1);
        debug_step = 1'b0; debug_step_cnt = 8'd0;
        tick;
        debug_step = 1'b1;
        tick;
        count_step("step0", 1);

        debug_step = 1'b0; debug_en = 1'b0;
        tick;
        check_eq("resume_halted", dbg_halted, 0);
        bp_valid = 1'b1; bp_pc = 32'h0000_0040; id_pc = 32'h0000_003C;
        #1;
        check_eq("bp_miss_cpu_en", cpu_en, 1);
        id_pc = 32'h0000_0040;
        #1;
        check_eq("bp_hit_cpu_en", cpu_en, 0);
        tick;
        check_eq("bp_halted", dbg_halted, 1);
        tick;
        check_eq("bp_stay_halted", dbg_halted, 1);
        debug_step_cnt = 8'd1; debug_step = 1'b1;
        tick;
        check_eq("bp_step_cpu_en", cpu_en, 1);
        id_pc = 32'h0000_0044;
        tick;
        check_eq("bp_step_done", dbg_halted, 1);
        debug_step = 1'b0;
        tick;
        check_eq("bp_resume", dbg_halted, 0);
        check_eq("bp_resume_cpu_en", cpu_en, 1);
        bp_valid = 1'b0;

        debug_en = 1'b1;
        tick;
        debug_step_cnt = 8'd5; debug_step = 1'b1;
        tick;
        check_eq("step5_running", cpu_en, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_step_cpu_rst", cpu_rst, 1);
        check_eq("rst_step_cpu_en", cpu_en, 1);
        tick;
        rst = 1'b0; debug_en = 1'b0;
        tick; tick; tick;
        check_eq("rst_step_run", dbg_halted, 0);
        check_eq("rst_step_en", cpu_en, 1);
        debug_en = 1'b1;
        tick; tick;
        check_eq("held_step_no_rearm", dbg_halted, 1);
        check_eq("held_step_cpu_en", cpu_en, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
